// File: rtl/math_coproc.sv
// Memory-mapped 16x16 unsigned multiply/divide coprocessor with CPU stall and level interrupt.
// The divider is built only when MATH_COPROC_DIV_EN is defined.
module math_coproc (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [3:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       irq
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [31:0] p_q, p_d, res_q, res_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ie_q, ie_d, done_q, done_d;
    logic [7:0]  dout_q, dout_d, rdata;
    logic        wr, rd, busy, op_mul, op_div, start, finish, dz;
    logic [16:0] mul_sum;
    logic [31:0] mul_p;

`ifdef MATH_COPROC_DIV_EN
    localparam logic DivPresent = 1'b1;
    logic        div_q, div_d, dz_q, dz_d;
    logic        div_ge;
    logic [15:0] div_diff;
    logic [31:0] div_p;

    assign op_div   = (din[1:0] == 2'b10);
    assign dz       = dz_q;
    // Remainder lives in p[31:16]; dividend bits shift out of p[15:0] as quotient bits shift in.
    assign div_ge   = (p_q[31:15] >= {1'b0, m_q});
    assign div_diff = p_q[30:15] - m_q;
    assign div_p    = div_ge ? {div_diff, p_q[14:0], 1'b1} : {p_q[30:0], 1'b0};
`else
    localparam logic DivPresent = 1'b0;
    assign op_div = 1'b0;
    assign dz     = 1'b0;
`endif

    assign wr      = cs & we;
    assign rd      = cs & ~we;
    assign busy    = (state_q != StIdle);
    assign rdy     = ~(rd && (addr[3:2] == 2'b10) && (state_q == StRun));
    assign irq     = done_q & ie_q;
    assign dout    = dout_q;
    assign op_mul  = (din[1:0] == 2'b01);
    assign start   = wr && (addr == 4'd4) && (state_q == StIdle) && (op_mul || op_div);
    // Shift-add: product high half accumulates, multiplier shifts out of the low half.
    assign mul_sum = {1'b0, p_q[31:16]} + (p_q[0] ? {1'b0, m_q} : 17'd0);
    assign mul_p   = {mul_sum, p_q[15:1]};

    always_comb begin
        rdata = 8'h00;
        case (addr)
            4'd0:    rdata = a_q[7:0];
            4'd1:    rdata = a_q[15:8];
            4'd2:    rdata = b_q[7:0];
            4'd3:    rdata = b_q[15:8];
            4'd5:    rdata = {ie_q, 3'b000, DivPresent, dz, done_q, busy};
            4'd8:    rdata = res_q[7:0];
            4'd9:    rdata = res_q[15:8];
            4'd10:   rdata = res_q[23:16];
            4'd11:   rdata = res_q[31:24];
            default: rdata = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        p_d     = p_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ie_d    = ie_q;
        done_d  = done_q;
        finish  = 1'b0;
        dout_d  = (rd && rdy) ? rdata : dout_q;
`ifdef MATH_COPROC_DIV_EN
        div_d   = div_q;
        dz_d    = dz_q;
`endif
        if (wr) begin
            case (addr)
                4'd0:    a_d[7:0]  = din;
                4'd1:    a_d[15:8] = din;
                4'd2:    b_d[7:0]  = din;
                4'd3:    b_d[15:8] = din;
                4'd4:    ie_d      = din[7];
                default: ;
            endcase
        end
        if (rd && (addr == 4'd5)) begin
            done_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = 4'd0;
                    p_d     = {16'h0000, a_q};
                    m_d     = b_q;
`ifdef MATH_COPROC_DIV_EN
                    div_d   = op_div;
                    dz_d    = 1'b0;
`endif
                end
            end
            StRun: begin
                cnt_d  = cnt_q + 4'd1;
                finish = (cnt_q == 4'd15);
                p_d    = mul_p;
`ifdef MATH_COPROC_DIV_EN
                if (div_q) begin
                    if (m_q == 16'h0000) begin
                        finish = 1'b1;
                        dz_d   = 1'b1;
                        p_d    = {p_q[15:0], 16'hFFFF};
                    end else begin
                        p_d = div_p;
                    end
                end
`endif
                // Late done-set wins over a same-cycle STATUS-read clear.
                if (finish) begin
                    state_d = StDone;
                    res_d   = p_d;
                    done_d  = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            m_q     <= 16'h0000;
            p_q     <= 32'h0;
            res_q   <= 32'h0;
            cnt_q   <= 4'd0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 8'h00;
`ifdef MATH_COPROC_DIV_EN
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            p_q     <= p_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
`ifdef MATH_COPROC_DIV_EN
            div_q   <= div_d;
            dz_q    <= dz_d;
`endif
        end
    end
endmodule
